tpu_regfile: RTL and testbench

//  Host-side register file that sits directly upstream of the tpu and drives its configuration inputs.

---
 rtl/tpu_pkg.sv | 32 +++
 rtl/tpu_bus_if.sv | 43 ++++
 rtl/tpu_regfile.sv | 115 +++++++++++
 tb/tb_tpu_regfile.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared definitions for the tpu host register file: address map, bit positions,
// bus handshake states and the configuration bundle driven to the tpu.
package tpu_pkg;

    localparam int ADDR_CTRL   = 0;
    localparam int ADDR_TXSLOT = 1;
    localparam int ADDR_RXSLOT = 2;
    localparam int ADDR_TIMVAL = 3;
    localparam int ADDR_STATUS = 4;
    localparam int ADDR_EVTCNT = 5;

    localparam int CTRL_MSK    = 0;
    localparam int CTRL_TX_EN  = 1;
    localparam int CTRL_RX_EN  = 2;
    localparam int CTRL_IMM    = 3;

    localparam int STAT_INTFLAG  = 0;
    localparam int STAT_PENDING  = 1;
    localparam int STAT_CONFLICT = 2;

    typedef enum logic [1:0] {IDLE, ACK, HOLD} bus_state_t;

    typedef struct packed {
        logic        msk;
        logic        tx_en;
        logic        rx_en;
        logic [7:0]  tx_slot;
        logic [7:0]  rx_slot;
        logic [15:0] timval;
    } tpu_cfg_t;

endpackage

// File: rtl/tpu_bus_if.sv
// Request/ready handshake: one acknowledge per BUS_SEL assertion, with a capture
// strobe for read data and a write strobe on the acknowledge edge.
module tpu_bus_if
    import tpu_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic sel,
    input  logic wr,
    output logic ready,
    output logic cap_stb,
    output logic wr_stb
);

    bus_state_t state, state_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // HOLD swallows a still-asserted select so an access is never repeated
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        cap_stb   = 1'b0;
        wr_stb    = 1'b0;
        case (state)
            IDLE: if (sel) begin
                state_nxt = ACK;
                cap_stb   = 1'b1;
            end
            ACK: begin
                ready     = 1'b1;
                wr_stb    = wr;
                state_nxt = HOLD;
            end
            HOLD: if (!sel) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: rtl/tpu_regfile.sv
// Double-buffered tpu configuration registers with frame-aligned commit, sticky
// timer interrupt and saturating timer event counter.
module tpu_regfile
    import tpu_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
) (
    input  logic              SYS_CLK,
    input  logic              RSTTPU_N,
    input  logic              BUS_SEL,
    input  logic              BUS_WR,
    input  logic [ADDR_W-1:0] BUS_ADDR,
    input  logic [DATA_W-1:0] BUS_WDATA,
    output logic [DATA_W-1:0] BUS_RDATA,
    output logic              BUS_READY,
    input  logic              FRAME_SYNC,
    input  logic              TIMER_EVT,
    output logic              TIMERINTMSK,
    output logic              TXSLOT_EN,
    output logic              RXSLOT_EN,
    output logic [7:0]        TX_SLOT,
    output logic [7:0]        RX_SLOT,
    output logic [15:0]       TIMER_INT_VALUE,
    output logic              INTFLAG
);

    logic        cap_stb, wr_stb;
    tpu_cfg_t    stg, act;
    logic        stg_imm, pending, intflag, conflict, commit;
    logic [15:0] evtcnt, rd_word;
    logic        hit_ctrl, hit_tx, hit_rx, hit_tim, hit_stat, hit_cnt, wr_stg;

    tpu_bus_if u_bus_if (
        .clk     (SYS_CLK),
        .rst_n   (RSTTPU_N),
        .sel     (BUS_SEL),
        .wr      (BUS_WR),
        .ready   (BUS_READY),
        .cap_stb (cap_stb),
        .wr_stb  (wr_stb)
    );

    assign hit_ctrl = (BUS_ADDR == ADDR_W'(ADDR_CTRL));
    assign hit_tx   = (BUS_ADDR == ADDR_W'(ADDR_TXSLOT));
    assign hit_rx   = (BUS_ADDR == ADDR_W'(ADDR_RXSLOT));
    assign hit_tim  = (BUS_ADDR == ADDR_W'(ADDR_TIMVAL));
    assign hit_stat = (BUS_ADDR == ADDR_W'(ADDR_STATUS));
    assign hit_cnt  = (BUS_ADDR == ADDR_W'(ADDR_EVTCNT));
    assign wr_stg   = wr_stb & (hit_ctrl | hit_tx | hit_rx | hit_tim);

    // Commit copies pre-write staging; a coincident staging write keeps PENDING set
    assign commit   = pending & (FRAME_SYNC | stg_imm);
    assign conflict = act.tx_en & act.rx_en & (act.tx_slot == act.rx_slot);

    always_comb begin
        rd_word = '0;
        if (hit_ctrl) rd_word[3:0] = {stg_imm, stg.rx_en, stg.tx_en, stg.msk};
        if (hit_tx)   rd_word[7:0] = stg.tx_slot;
        if (hit_rx)   rd_word[7:0] = stg.rx_slot;
        if (hit_tim)  rd_word      = stg.timval;
        if (hit_stat) begin
            rd_word[STAT_INTFLAG]  = intflag;
            rd_word[STAT_PENDING]  = pending;
            rd_word[STAT_CONFLICT] = conflict;
        end
        if (hit_cnt)  rd_word      = evtcnt;
    end

    always_ff @(posedge SYS_CLK or negedge RSTTPU_N) begin
        if (!RSTTPU_N) begin
            stg       <= '0;
            stg_imm   <= 1'b0;
            act       <= '0;
            pending   <= 1'b0;
            BUS_RDATA <= '0;
        end else begin
            if (cap_stb) BUS_RDATA <= DATA_W'(rd_word);
            if (commit)  act <= stg;
            if (wr_stg)      pending <= 1'b1;
            else if (commit) pending <= 1'b0;
            if (wr_stb && hit_ctrl) begin
                stg.msk   <= BUS_WDATA[CTRL_MSK];
                stg.tx_en <= BUS_WDATA[CTRL_TX_EN];
                stg.rx_en <= BUS_WDATA[CTRL_RX_EN];
                stg_imm   <= BUS_WDATA[CTRL_IMM];
            end
            if (wr_stb && hit_tx)  stg.tx_slot <= BUS_WDATA[7:0];
            if (wr_stb && hit_rx)  stg.rx_slot <= BUS_WDATA[7:0];
            if (wr_stb && hit_tim) stg.timval  <= BUS_WDATA[15:0];
        end
    end

    // Interrupt set beats W1C; counter clear beats saturation but still counts a coincident event
    always_ff @(posedge SYS_CLK or negedge RSTTPU_N) begin
        if (!RSTTPU_N) begin
            intflag <= 1'b0;
            evtcnt  <= '0;
        end else begin
            if (TIMER_EVT && act.msk)                          intflag <= 1'b1;
            else if (wr_stb && hit_stat && BUS_WDATA[STAT_INTFLAG]) intflag <= 1'b0;
            if (wr_stb && hit_cnt)                 evtcnt <= {15'd0, TIMER_EVT};
            else if (TIMER_EVT && evtcnt != 16'hFFFF) evtcnt <= evtcnt + 16'd1;
        end
    end

    assign TIMERINTMSK     = act.msk;
    assign TXSLOT_EN       = act.tx_en;
    assign RXSLOT_EN       = act.rx_en & ~conflict;
    assign TX_SLOT         = act.tx_slot;
    assign RX_SLOT         = act.rx_slot;
    assign TIMER_INT_VALUE = act.timval;
    assign INTFLAG         = intflag;

endmodule

// File: tb/tb_tpu_regfile.sv
// Bench for tpu_regfile: directed scenarios plus random bus/frame/timer traffic,
// with read data checked through a scoreboard against a behavioural model.
module tb_tpu_regfile;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 16;

    logic              SYS_CLK = 1'b0;
    logic              RSTTPU_N = 1'b0;
    logic              BUS_SEL = 1'b0;
    logic              BUS_WR = 1'b0;
    logic [ADDR_W-1:0] BUS_ADDR = '0;
    logic [DATA_W-1:0] BUS_WDATA = '0;
    logic [DATA_W-1:0] BUS_RDATA;
    logic              BUS_READY;
    logic              FRAME_SYNC = 1'b0;
    logic              TIMER_EVT = 1'b0;
    logic              TIMERINTMSK, TXSLOT_EN, RXSLOT_EN, INTFLAG;
    logic [7:0]        TX_SLOT, RX_SLOT;
    logic [15:0]       TIMER_INT_VALUE;

    tpu_regfile #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .SYS_CLK(SYS_CLK), .RSTTPU_N(RSTTPU_N), .BUS_SEL(BUS_SEL), .BUS_WR(BUS_WR),
        .BUS_ADDR(BUS_ADDR), .BUS_WDATA(BUS_WDATA), .BUS_RDATA(BUS_RDATA),
        .BUS_READY(BUS_READY), .FRAME_SYNC(FRAME_SYNC), .TIMER_EVT(TIMER_EVT),
        .TIMERINTMSK(TIMERINTMSK), .TXSLOT_EN(TXSLOT_EN), .RXSLOT_EN(RXSLOT_EN),
        .TX_SLOT(TX_SLOT), .RX_SLOT(RX_SLOT), .TIMER_INT_VALUE(TIMER_INT_VALUE),
        .INTFLAG(INTFLAG)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    int checks = 0;
    int passes = 0;
    int ready_cnt = 0;

    typedef struct {
        bit          is_rd;
        int          addr;
        logic [15:0] exp;
    } exp_t;
    exp_t sbq[$];

    // Reference model: staging and active register images plus status
    logic [3:0]  m_ctrl;
    logic [7:0]  m_tx, m_rx;
    logic [15:0] m_tim;
    bit          a_msk, a_txen, a_rxen;
    logic [7:0]  a_tx, a_rx;
    logic [15:0] a_tim;
    bit          m_pend, m_flag;
    int          m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_ctrl = '0; m_tx = '0; m_rx = '0; m_tim = '0;
        a_msk = 0; a_txen = 0; a_rxen = 0; a_tx = '0; a_rx = '0; a_tim = '0;
        m_pend = 0; m_flag = 0; m_cnt = 0;
    endtask

    function automatic bit m_conflict();
        return a_txen && a_rxen && (a_tx == a_rx);
    endfunction

    function automatic logic [15:0] m_read(input int addr);
        case (addr)
            0: return {12'd0, m_ctrl};
            1: return {8'd0, m_tx};
            2: return {8'd0, m_rx};
            3: return m_tim;
            4: return {13'd0, m_conflict(), m_pend, m_flag};
            5: return m_cnt[15:0];
            default: return 16'd0;
        endcase
    endfunction

    // Applies one clock edge's worth of rules to the model, using pre-edge state
    task automatic model_edge(input bit wr, input int addr, input logic [15:0] wd,
                              input bit fs, input bit te);
        bit commit, wr_stg, old_msk;
        commit  = m_pend && (fs || m_ctrl[3]);
        wr_stg  = wr && (addr < 4);
        old_msk = a_msk;
        if (commit) begin
            a_msk = m_ctrl[0]; a_txen = m_ctrl[1]; a_rxen = m_ctrl[2];
            a_tx = m_tx; a_rx = m_rx; a_tim = m_tim;
        end
        if (wr_stg) m_pend = 1;
        else if (commit) m_pend = 0;
        if (te && old_msk) m_flag = 1;
        else if (wr && addr == 4 && wd[0]) m_flag = 0;
        if (wr && addr == 5) m_cnt = te ? 1 : 0;
        else if (te && m_cnt < 65535) m_cnt++;
        if (wr) begin
            case (addr)
                0: m_ctrl = wd[3:0];
                1: m_tx = wd[7:0];
                2: m_rx = wd[7:0];
                3: m_tim = wd;
                default: ;
            endcase
        end
    endtask

    // Called just after a falling edge; returns just after the next falling edge
    task automatic tick(input bit wr, input int addr, input logic [15:0] wd,
                        input bit fs, input bit te);
        FRAME_SYNC = fs;
        TIMER_EVT  = te;
        model_edge(wr, addr, wd, fs, te);
        @(posedge SYS_CLK);
        @(negedge SYS_CLK);
        FRAME_SYNC = 1'b0;
        TIMER_EVT  = 1'b0;
    endtask

    task automatic bus_access(input bit wr, input int addr, input logic [15:0] wd,
                              input bit fs, input bit te);
        exp_t e;
        BUS_SEL = 1'b1; BUS_WR = wr; BUS_ADDR = addr[ADDR_W-1:0]; BUS_WDATA = wd;
        e.is_rd = !wr; e.addr = addr; e.exp = m_read(addr);
        sbq.push_back(e);
        tick(0, 0, 16'd0, 0, 0);
        check("ready_latency", BUS_READY, 1);
        tick(wr, addr, wd, fs, te);
        BUS_SEL = 1'b0; BUS_WR = 1'b0;
        tick(0, 0, 16'd0, 0, 0);
    endtask

    task automatic bus_write(input int addr, input logic [15:0] wd,
                             input bit fs = 0, input bit te = 0);
        bus_access(1, addr, wd, fs, te);
    endtask

    task automatic bus_read(input int addr);
        bus_access(0, addr, 16'd0, 0, 0);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_msk"},   TIMERINTMSK, a_msk);
        check({tag, "_txen"},  TXSLOT_EN, a_txen);
        check({tag, "_rxen"},  RXSLOT_EN, a_rxen && !(a_txen && a_rxen && a_tx == a_rx));
        check({tag, "_tx"},    TX_SLOT, a_tx);
        check({tag, "_rx"},    RX_SLOT, a_rx);
        check({tag, "_tim"},   TIMER_INT_VALUE, a_tim);
        check({tag, "_flag"},  INTFLAG, m_flag);
    endtask

    // Monitor: every acknowledge must match an issued access
    always @(negedge SYS_CLK) begin
        if (RSTTPU_N && BUS_READY) begin
            ready_cnt++;
            if (sbq.size() == 0) begin
                check("unexpected_ready", 1, 0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                if (e.is_rd) check($sformatf("rdata_a%0d", e.addr), BUS_RDATA, e.exp);
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc0;
        model_reset();
        repeat (3) @(negedge SYS_CLK);
        check_outputs("rst");
        check("rst_ready", BUS_READY, 0);
        check("rst_rdata", BUS_RDATA, 0);
        RSTTPU_N = 1'b1;
        tick(0, 0, 16'd0, 0, 0);

        // Reset values, then one acknowledge for a long-held select
        for (int a = 0; a < 8; a++) bus_read(a);
        rc0 = ready_cnt;
        BUS_SEL = 1'b1; BUS_WR = 1'b0; BUS_ADDR = 4'd1;
        sbq.push_back('{1, 1, m_read(1)});
        repeat (5) tick(0, 0, 16'd0, 0, 0);
        BUS_SEL = 1'b0;
        tick(0, 0, 16'd0, 0, 0);
        check("one_ready_per_sel", ready_cnt - rc0, 1);

        // Staged writes commit only on FRAME_SYNC
        bus_write(1, 16'd60);
        bus_write(2, 16'd120);
        bus_write(3, 16'd33000);
        bus_write(0, 16'h0007);
        check_outputs("staged");
        check("staged_tx_unchanged", TX_SLOT, 0);
        bus_read(4);
        tick(0, 0, 16'd0, 1, 0);
        check_outputs("commit");
        check("commit_tx", TX_SLOT, 60);
        check("commit_tim", TIMER_INT_VALUE, 33000);
        check("commit_rxen", RXSLOT_EN, 1);
        bus_read(4);

        // Write coinciding with FRAME_SYNC
        bus_write(1, 16'd30, 1, 0);
        check("coincident_tx_old", TX_SLOT, 60);
        bus_read(4);
        tick(0, 0, 16'd0, 1, 0);
        check("coincident_tx_new", TX_SLOT, 30);
        check_outputs("coincident");

        // Interrupt flag set/clear priority and mask
        tick(0, 0, 16'd0, 0, 1);
        check("intflag_set", INTFLAG, 1);
        bus_write(4, 16'h0001, 0, 1);
        check("intflag_set_wins", INTFLAG, 1);
        bus_write(4, 16'h0001);
        check("intflag_w1c", INTFLAG, 0);
        bus_write(0, 16'h0006);
        tick(0, 0, 16'd0, 1, 0);
        tick(0, 0, 16'd0, 0, 1);
        check("intflag_masked", INTFLAG, 0);
        bus_read(5);
        check_outputs("irq");

        // Slot conflict suppresses RX enable; IMMEDIATE commits without FRAME_SYNC
        bus_write(1, 16'd45);
        bus_write(2, 16'd45);
        tick(0, 0, 16'd0, 1, 0);
        check("conflict_rxen", RXSLOT_EN, 0);
        bus_read(4);
        bus_write(0, 16'h000E);
        bus_write(2, 16'd46);
        check("immediate_rx", RX_SLOT, 46);
        check("immediate_rxen", RXSLOT_EN, 1);
        check_outputs("conflict");
        bus_write(0, 16'h0006);

        // Randomised traffic
        for (int i = 0; i < 250; i++) begin
            int op;
            op = $urandom_range(0, 3);
            case (op)
                0: bus_write($urandom_range(0, 7), 16'($urandom),
                             $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
                1: bus_read($urandom_range(0, 7));
                default: tick(0, 0, 16'd0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
            endcase
            check_outputs("rand");
        end

        // Counter saturation and clear-with-event
        bus_write(5, 16'd0);
        repeat (65535) tick(0, 0, 16'd0, 0, 1);
        bus_read(5);
        repeat (3) tick(0, 0, 16'd0, 0, 1);
        bus_read(5);
        bus_write(5, 16'd0, 0, 1);
        bus_read(5);
        check_outputs("sat");

        // Reset asserted while the acknowledge is showing
        BUS_SEL = 1'b1; BUS_WR = 1'b0; BUS_ADDR = 4'd3;
        sbq.push_back('{1, 3, m_read(3)});
        tick(0, 0, 16'd0, 0, 0);
        #2 RSTTPU_N = 1'b0;
        #1 check("async_rst_ready", BUS_READY, 0);
        model_reset();
        BUS_SEL = 1'b0;
        @(negedge SYS_CLK);
        check_outputs("midrst");
        RSTTPU_N = 1'b1;
        tick(0, 0, 16'd0, 0, 0);
        bus_read(5);
        bus_read(4);

        tick(0, 0, 16'd0, 0, 0);
        check("scoreboard_drained", sbq.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
